// File: rtl/plane_pixel_serializer.sv
// plane_pixel_serializer
//
// Captures the GFX ROM tile rows and COL attributes that the plane address
// generator fetches for the fix, A and B planes. At each tile boundary the
// staged rows move into a two-tile pixel window per layer. In every pixel slot
// one 4bpp pixel per layer is emitted. X flip is applied when the row is
// captured, and fine scroll is applied when the pixel is selected.
//
// Ports
//   clk_24M            system clock, rising edge
//   nRES               asynchronous active-low reset
//   PIX_CE             pixel strobe, one clk_24M in every 4
//   TILE_LD            tile boundary, qualified by PIX_CE, on the last slot of a tile
//   ROM_STB            ROM word valid for one clk_24M
//   ROM_SEL[1:0]       target layer of ROM_STB: 0 fix, 1 A, 2 B, 3 none
//   VD_ROM[31:0]       tile row, byte k = bitplane k, bit 7 = leftmost pixel
//   COL_IN[7:0]        tile attribute, captured with ROM_STB
//   ZA[2:0], ZB[2:0]   fine scroll for layers A and B, sampled on TILE_LD
//   FLIP_X_EN          enables the per-tile X flip requested by COL_IN[0]
//   PX_F/A/B[3:0]      pixel codes, registered
//   COL_F/A/B[7:0]     attribute of the tile that supplied the pixel
//   NZ_F/A/B           set when the matching pixel code is nonzero

module plane_pixel_serializer (
   input  logic        clk_24M,
   input  logic        nRES,
   input  logic        PIX_CE,
   input  logic        TILE_LD,
   input  logic        ROM_STB,
   input  logic [1:0]  ROM_SEL,
   input  logic [31:0] VD_ROM,
   input  logic [7:0]  COL_IN,
   input  logic [2:0]  ZA,
   input  logic [2:0]  ZB,
   input  logic        FLIP_X_EN,
   output logic [3:0]  PX_F,
   output logic [3:0]  PX_A,
   output logic [3:0]  PX_B,
   output logic [7:0]  COL_F,
   output logic [7:0]  COL_A,
   output logic [7:0]  COL_B,
   output logic        NZ_F,
   output logic        NZ_A,
   output logic        NZ_B
);

   // Layer index: 0 fix, 1 A, 2 B.
   localparam int N_LAYER = 3;

   logic [3:0] stage_px  [N_LAYER][8];
   logic [7:0] stage_col [N_LAYER];
   // Window slots 0-7 hold the previous tile, slots 8-15 hold the current tile.
   logic [3:0] win_px    [N_LAYER][16];
   logic [7:0] prev_col  [N_LAYER];
   logic [7:0] cur_col   [N_LAYER];
   logic [2:0] fine_a;
   logic [2:0] fine_b;
   logic [2:0] phase;

   logic [3:0] px_q  [N_LAYER];
   logic [7:0] col_q [N_LAYER];
   logic       nz_q  [N_LAYER];

   logic [3:0] dec_px [8];
   logic [3:0] ins_px [8];
   logic       do_flip;
   logic       tile_adv;

   logic [2:0] fine   [N_LAYER];
   logic [3:0] idx    [N_LAYER];
   logic [3:0] sel_px [N_LAYER];
   logic [7:0] sel_col[N_LAYER];

   assign do_flip  = FLIP_X_EN & COL_IN[0];
   assign tile_adv = PIX_CE & TILE_LD;

   // Pixel n gathers bit (7-n) from each of the four bitplane bytes.
   always_comb begin
      for (int n = 0; n < 8; n++) begin
         dec_px[n] = {VD_ROM[31-n], VD_ROM[23-n], VD_ROM[15-n], VD_ROM[7-n]};
      end
      for (int n = 0; n < 8; n++) begin
         ins_px[n] = do_flip ? dec_px[7-n] : dec_px[n];
      end
   end

   // Staging registers. ROM_SEL=3 matches no layer and leaves everything alone.
   always_ff @(posedge clk_24M or negedge nRES) begin
      if (!nRES) begin
         for (int l = 0; l < N_LAYER; l++) begin
            stage_col[l] <= '0;
            for (int n = 0; n < 8; n++) stage_px[l][n] <= '0;
         end
      end else if (ROM_STB) begin
         for (int l = 0; l < N_LAYER; l++) begin
            if (ROM_SEL == 2'(l)) begin
               stage_col[l] <= COL_IN;
               for (int n = 0; n < 8; n++) stage_px[l][n] <= ins_px[n];
            end
         end
      end
   end

   // Tile advance. A ROM word arriving in the same cycle lands in the stage,
   // while cur takes the old stage, so the new word appears one tile later.
   always_ff @(posedge clk_24M or negedge nRES) begin
      if (!nRES) begin
         for (int l = 0; l < N_LAYER; l++) begin
            prev_col[l] <= '0;
            cur_col[l]  <= '0;
            for (int s = 0; s < 16; s++) win_px[l][s] <= '0;
         end
         fine_a <= '0;
         fine_b <= '0;
      end else if (tile_adv) begin
         for (int l = 0; l < N_LAYER; l++) begin
            prev_col[l] <= cur_col[l];
            cur_col[l]  <= stage_col[l];
            for (int s = 0; s < 8; s++) begin
               win_px[l][s]   <= win_px[l][s+8];
               win_px[l][s+8] <= stage_px[l][s];
            end
         end
         fine_a <= ZA;
         fine_b <= ZB;
      end
   end

   // Pixel phase within the tile. Without a TILE_LD it simply wraps 7 -> 0.
   always_ff @(posedge clk_24M or negedge nRES) begin
      if (!nRES) begin
         phase <= '0;
      end else if (PIX_CE) begin
         if (TILE_LD) phase <= '0;
         else         phase <= phase + 3'd1;
      end
   end

   // Fine scroll shifts right: idx = 8 + phase - fine reaches back into the
   // previous tile for the first 'fine' pixels. Since fine <= 7 and
   // phase >= 0, idx stays within 1..15.
   always_comb begin
      fine[0] = 3'd0;
      fine[1] = fine_a;
      fine[2] = fine_b;
      for (int l = 0; l < N_LAYER; l++) begin
         idx[l]     = 4'd8 + {1'b0, phase} - {1'b0, fine[l]};
         sel_px[l]  = win_px[l][idx[l]];
         sel_col[l] = idx[l][3] ? cur_col[l] : prev_col[l];
      end
   end

   always_ff @(posedge clk_24M or negedge nRES) begin
      if (!nRES) begin
         for (int l = 0; l < N_LAYER; l++) begin
            px_q[l]  <= '0;
            col_q[l] <= '0;
            nz_q[l]  <= 1'b0;
         end
      end else if (PIX_CE) begin
         for (int l = 0; l < N_LAYER; l++) begin
            px_q[l]  <= sel_px[l];
            col_q[l] <= sel_col[l];
            nz_q[l]  <= (sel_px[l] != 4'd0);
         end
      end
   end

   assign PX_F  = px_q[0];
   assign PX_A  = px_q[1];
   assign PX_B  = px_q[2];
   assign COL_F = col_q[0];
   assign COL_A = col_q[1];
   assign COL_B = col_q[2];
   assign NZ_F  = nz_q[0];
   assign NZ_A  = nz_q[1];
   assign NZ_B  = nz_q[2];

endmodule
